src_fifo: RTL and testbench

- Show-ahead synchronous FIFO directly upstream of the running-max reader stage.
- The producer pushes 8-bit samples with wrreq.
- The reader watches empty, pulses rdreq to pop, and consumes q as the current head word.
- Also provides fill level, near-full warning and sticky overflow/underflow error flags for the controller.

---
 rtl/src_fifo_pkg.sv | 9 +
 rtl/src_fifo_ctrl.sv | 65 ++++++
 rtl/src_fifo.sv | 58 +++++
 tb/tb_src_fifo.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/src_fifo_pkg.sv
// Shared defaults and types for the show-ahead source FIFO feeding the running-max reader.
package src_fifo_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 16;

  typedef logic [DW_DEF-1:0] word_t;

endpackage

// File: rtl/src_fifo_ctrl.sv
// Pointer, occupancy, flag and sticky-error bookkeeping for src_fifo.
module src_fifo_ctrl
  import src_fifo_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = 12
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       clr,
  input  logic                       wrreq,
  input  logic                       rdreq,
  output logic                       wr_ok,
  output logic [$clog2(DEPTH)-1:0]   wp,
  output logic [$clog2(DEPTH)-1:0]   rp,
  output logic [$clog2(DEPTH):0]     usedw,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       ovf,
  output logic                       udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);

  logic rd_ok;

  assign empty       = (usedw == '0);
  assign full        = (usedw == FULL_CNT);
  assign almost_full = (usedw >= AF_CNT);

  // A read on a full FIFO frees the slot in the same edge, so the write may proceed.
  assign rd_ok = ~clr & rdreq & ~empty;
  assign wr_ok = ~clr & wrreq & (~full | rdreq);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wp    <= '0;
      rp    <= '0;
      usedw <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      usedw <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   usedw <= usedw + CW'(1);
        2'b01:   usedw <= usedw - CW'(1);
        default: usedw <= usedw;
      endcase
      if (wrreq & full & ~rdreq) ovf <= 1'b1;
      if (rdreq & empty)         udf <= 1'b1;
    end
  end

endmodule

// File: rtl/src_fifo.sv
// Show-ahead synchronous FIFO: register-array storage with the head word presented on q.
module src_fifo
  import src_fifo_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = 12
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     clr,
  input  logic                     wrreq,
  input  logic [DW-1:0]            data,
  input  logic                     rdreq,
  output logic [DW-1:0]            q,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic          wr_ok;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  src_fifo_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) u_ctrl (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .clr         (clr),
    .wrreq       (wrreq),
    .rdreq       (rdreq),
    .wr_ok       (wr_ok),
    .wp          (wp),
    .rp          (rp),
    .usedw       (usedw),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .ovf         (ovf),
    .udf         (udf)
  );

  // Storage carries no reset; only words between rp and wp are ever observable.
  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wp] <= data;
  end

  assign q = empty ? '0 : mem[rp];

endmodule

// File: tb/tb_src_fifo.sv
// Self-checking bench for src_fifo against a queue-based reference model.
module tb_src_fifo;
  import src_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       clr = 1'b0;
  logic       wrreq = 1'b0;
  logic       rdreq = 1'b0;
  word_t      data = '0;
  word_t      q;
  logic       empty, full, almost_full, ovf, udf;
  logic [4:0] usedw;

  int    tests = 0;
  int    fails = 0;
  word_t mq[$];
  bit    movf = 1'b0;
  bit    mudf = 1'b0;

  src_fifo #(.DW(8), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .clr         (clr),
    .wrreq       (wrreq),
    .data        (data),
    .rdreq       (rdreq),
    .q           (q),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .usedw       (usedw),
    .ovf         (ovf),
    .udf         (udf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".usedw"}, 32'(usedw), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(mq.size() == DEPTH));
    chk({tag, ".af"},    32'(almost_full), 32'(mq.size() >= AF));
    chk({tag, ".ovf"},   32'(ovf), 32'(movf));
    chk({tag, ".udf"},   32'(udf), 32'(mudf));
    chk({tag, ".q"},     32'(q), (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, then compare.
  task automatic cyc(input string tag, input bit w, input word_t d, input bit r, input bit c);
    bit was_full, was_empty;
    wrreq = w; data = d; rdreq = r; clr = c;
    @(posedge CLK);
    if (c) begin
      mq.delete();
      movf = 1'b0;
      mudf = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (w && was_full && !r) movf = 1'b1;
      if (r && was_empty)      mudf = 1'b1;
      if (r && !was_empty) void'(mq.pop_front());
      if (w && (!was_full || r)) mq.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Power-on reset, checked before any clock edge.
    #2;
    check_all("por");
    #4 RSTn = 1'b1;

    // Async reset mid-operation discards stored words without a clock.
    cyc("pre", 1'b1, 8'hC1, 1'b0, 1'b0);
    cyc("pre", 1'b1, 8'hC2, 1'b0, 1'b0);
    #2 RSTn = 1'b0;
    mq.delete(); movf = 1'b0; mudf = 1'b0;
    #1;
    check_all("arst");
    chk("arst.q0", 32'(q), 32'h0);
    #3 RSTn = 1'b1;
    cyc("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // First-word timing.
    cyc("first", 1'b1, 8'h5A, 1'b0, 1'b0);
    chk("first.q", 32'(q), 32'h5A);
    chk("first.usedw", 32'(usedw), 32'd1);
    cyc("pop1", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop1.empty", 32'(empty), 32'd1);
    chk("pop1.q", 32'(q), 32'h0);

    // Fill, overflow, drain.
    for (int i = 1; i <= DEPTH; i++) begin
      cyc("fill", 1'b1, word_t'(i), 1'b0, 1'b0);
      chk("fill.af", 32'(almost_full), 32'(i >= AF));
    end
    chk("fill.full", 32'(full), 32'd1);
    cyc("ovfw", 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf.set", 32'(ovf), 32'd1);
    chk("ovf.usedw", 32'(usedw), 32'd16);
    for (int i = 1; i <= DEPTH; i++) begin
      chk("drain.order", 32'(q), 32'(i));
      cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    cyc("clr0", 1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap with concurrent traffic.
    for (int i = 0; i < 3; i++) cyc("preload", 1'b1, word_t'(8'hA0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cyc("wrap", 1'b1, word_t'(8'h40 + i), 1'b1, 1'b0);
      chk("wrap.usedw", 32'(usedw), 32'd3);
    end
    cyc("clr1", 1'b0, 8'h00, 1'b0, 1'b1);

    // Full plus simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) cyc("fill2", 1'b1, word_t'(8'h80 + i), 1'b0, 1'b0);
    cyc("fullrw", 1'b1, 8'h77, 1'b1, 1'b0);
    chk("fullrw.usedw", 32'(usedw), 32'd16);
    chk("fullrw.ovf", 32'(ovf), 32'd0);
    chk("fullrw.q", 32'(q), 32'h81);
    for (int i = 0; i < DEPTH; i++) cyc("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Empty plus simultaneous read and write.
    cyc("emptyrw", 1'b1, 8'h33, 1'b1, 1'b0);
    chk("emptyrw.udf", 32'(udf), 32'd1);
    chk("emptyrw.usedw", 32'(usedw), 32'd1);
    chk("emptyrw.q", 32'(q), 32'h33);
    cyc("clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Flush with a concurrent write: 5 words held and ovf set beforehand.
    for (int i = 0; i < DEPTH; i++) cyc("fill3", 1'b1, word_t'(i + 8'h10), 1'b0, 1'b0);
    cyc("ovf3", 1'b1, 8'hEE, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH - 5; i++) cyc("part", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("flush.pre_usedw", 32'(usedw), 32'd5);
    chk("flush.pre_ovf", 32'(ovf), 32'd1);
    cyc("flush", 1'b1, 8'hAB, 1'b0, 1'b1);
    chk("flush.usedw", 32'(usedw), 32'd0);
    chk("flush.ovf", 32'(ovf), 32'd0);
    cyc("flush.after", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("flush.notstored", 32'(empty), 32'd1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rand",
          $urandom_range(0, 99) < 55,
          word_t'($urandom_range(0, 255)),
          $urandom_range(0, 99) < 45,
          $urandom_range(0, 99) < 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
